// File: rtl/accel_job_scheduler_pkg.sv
// Shared types for the keccak job scheduler: FSM states, response status codes
// and the width of the RUN timeout counter.
package accel_job_scheduler_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_RUN,
      S_CLEAR,
      S_REPORT
   } sched_state_t;

   typedef enum logic [1:0] {
      STS_OK      = 2'd0,
      STS_TIMEOUT = 2'd1,
      STS_BADLEN  = 2'd2
   } sched_status_t;

   localparam int TIMER_W = 16;

endpackage

// File: rtl/accel_job_scheduler_sched_fifo.sv
// Synchronous FIFO holding pending scheduler commands; a push and a pop in the
// same cycle are both honoured, and pointers wrap modulo DEPTH.
module sched_fifo
   import accel_job_scheduler_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   // Requests against a full or empty queue are dropped here so callers can stay simple.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/accel_job_scheduler.sv
// Sequences queued hash jobs onto the single keccak accelerator: start, watch for
// done or timeout, clear the engine and hand back a tagged status with an irq.
module accel_job_scheduler
   import accel_job_scheduler_pkg::*;
#(
   parameter int LEN_W       = 6,
   parameter int TAG_W       = 4,
   parameter int QDEPTH      = 4,
   parameter int TIMEOUT_CYC = 1024,
   localparam int CNT_W      = $clog2(QDEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic             accel_start,
   output logic [LEN_W-1:0] accel_len,
   input  logic             accel_done,
   output logic             accel_clr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [1:0]       rsp_status,
   output logic             irq,
   output logic             busy,
   output logic [CNT_W-1:0] q_count
);

   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMEOUT_CYC - 1);

   sched_state_t        state_q, state_d;
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   sched_status_t       status_q, status_d;

   logic [LEN_W+TAG_W-1:0] fifo_head;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [LEN_W-1:0]       head_len;
   logic [TAG_W-1:0]       head_tag;

   sched_fifo #(
      .WIDTH (LEN_W + TAG_W),
      .DEPTH (QDEPTH)
   ) u_cmd_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_valid),
      .push_data ({cmd_tag, cmd_len}),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (q_count)
   );

   assign head_len = fifo_head[LEN_W-1:0];
   assign head_tag = fifo_head[LEN_W +: TAG_W];

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      len_d    = len_q;
      tag_d    = tag_q;
      status_d = status_q;
      fifo_pop = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               len_d    = head_len;
               tag_d    = head_tag;
               if (head_len == '0) begin
                  status_d = STS_BADLEN;
                  state_d  = S_REPORT;
               end else begin
                  state_d  = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            timer_d = TIMER_LOAD;
            state_d = S_RUN;
         end
         // A done arriving on the expiry cycle still counts as success.
         S_RUN: begin
            if (accel_done) begin
               status_d = STS_OK;
               state_d  = S_CLEAR;
            end else if (timer_q == '0) begin
               status_d = STS_TIMEOUT;
               state_d  = S_CLEAR;
            end else begin
               timer_d  = timer_q - TIMER_W'(1);
            end
         end
         S_CLEAR: begin
            state_d = S_REPORT;
         end
         S_REPORT: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         len_q    <= '0;
         tag_q    <= '0;
         status_q <= STS_OK;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         len_q    <= len_d;
         tag_q    <= tag_d;
         status_q <= status_d;
      end
   end

   assign cmd_ready   = !fifo_full;
   assign accel_start = (state_q == S_LAUNCH);
   assign accel_clr   = (state_q == S_CLEAR);
   assign rsp_valid   = (state_q == S_REPORT);
   assign irq         = rsp_valid;
   assign busy        = (state_q != S_IDLE) || !fifo_empty;
   assign accel_len   = len_q;
   assign rsp_tag     = tag_q;
   assign rsp_status  = status_q;

endmodule

// File: tb/tb_accel_job_scheduler.sv
// Scoreboard bench for accel_job_scheduler: a long-timeout instance for the job,
// queue, back-pressure and reset cases, and a TIMEOUT_CYC=16 instance for expiry.
module tb_accel_job_scheduler;
   import accel_job_scheduler_pkg::*;

   localparam int LEN_W     = 6;
   localparam int TAG_W     = 4;
   localparam int QDEPTH    = 4;
   localparam int CNT_W     = 3;
   localparam int TMO_MAIN  = 64;
   localparam int TMO_SHORT = 16;

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [1:0]       status;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             cmd_valid, cmd_ready, accel_start, accel_done, accel_clr;
   logic             rsp_valid, rsp_ready, irq, busy;
   logic [LEN_W-1:0] cmd_len, accel_len;
   logic [TAG_W-1:0] cmd_tag, rsp_tag;
   logic [1:0]       rsp_status;
   logic [CNT_W-1:0] q_count;

   logic             t_cmd_valid, t_cmd_ready, t_accel_start, t_accel_done, t_accel_clr;
   logic             t_rsp_valid, t_rsp_ready, t_irq, t_busy;
   logic [LEN_W-1:0] t_cmd_len, t_accel_len;
   logic [TAG_W-1:0] t_cmd_tag, t_rsp_tag;
   logic [1:0]       t_rsp_status;
   logic [CNT_W-1:0] t_q_count;

   int tests_run = 0;
   int tests_failed = 0;
   int edge_cnt = 0;
   int done_delay = 0;
   int t_done_delay = 0;
   int n_start = 0, n_clr = 0, n_rsp = 0, start_edge = 0, clr_edge = 0;
   int t_n_start = 0, t_n_clr = 0, t_n_rsp = 0, t_start_edge = 0, t_clr_edge = 0;
   int start_len = 0;
   int accept_edge = 0;
   exp_t exp_q[$];
   exp_t t_exp_q[$];

   accel_job_scheduler #(
      .LEN_W(LEN_W), .TAG_W(TAG_W), .QDEPTH(QDEPTH), .TIMEOUT_CYC(TMO_MAIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_len(cmd_len), .cmd_tag(cmd_tag), .accel_start(accel_start),
      .accel_len(accel_len), .accel_done(accel_done), .accel_clr(accel_clr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
      .rsp_status(rsp_status), .irq(irq), .busy(busy), .q_count(q_count)
   );

   accel_job_scheduler #(
      .LEN_W(LEN_W), .TAG_W(TAG_W), .QDEPTH(QDEPTH), .TIMEOUT_CYC(TMO_SHORT)
   ) dut_t (
      .clk(clk), .rst_n(rst_n), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready),
      .cmd_len(t_cmd_len), .cmd_tag(t_cmd_tag), .accel_start(t_accel_start),
      .accel_len(t_accel_len), .accel_done(t_accel_done), .accel_clr(t_accel_clr),
      .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_tag(t_rsp_tag),
      .rsp_status(t_rsp_status), .irq(t_irq), .busy(t_busy), .q_count(t_q_count)
   );

   // Edge counter: after active edge k it reads k.
   always @(posedge clk) edge_cnt++;

   // Accelerator models: done rises done_delay cycles after the start cycle
   // (never when the delay is 0) and stays high until the clear pulse.
   int  mcnt, t_mcnt;
   logic marmed, t_marmed;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accel_done <= 1'b0; marmed <= 1'b0; mcnt <= 0;
      end else if (accel_clr) begin
         accel_done <= 1'b0; marmed <= 1'b0;
      end else if (accel_start) begin
         marmed <= (done_delay > 0); mcnt <= 1;
      end else if (marmed) begin
         if (mcnt == done_delay - 1) begin
            accel_done <= 1'b1; marmed <= 1'b0;
         end else mcnt <= mcnt + 1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_accel_done <= 1'b0; t_marmed <= 1'b0; t_mcnt <= 0;
      end else if (t_accel_clr) begin
         t_accel_done <= 1'b0; t_marmed <= 1'b0;
      end else if (t_accel_start) begin
         t_marmed <= (t_done_delay > 0); t_mcnt <= 1;
      end else if (t_marmed) begin
         if (t_mcnt == t_done_delay - 1) begin
            t_accel_done <= 1'b1; t_marmed <= 1'b0;
         end else t_mcnt <= t_mcnt + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitors sample away from the active edge and pop the scoreboard on each response.
   always @(negedge clk) begin
      exp_t e;
      if (accel_start) begin n_start++; start_edge = edge_cnt; start_len = int'(accel_len); end
      if (accel_clr) begin n_clr++; clr_edge = edge_cnt; end
      if (rsp_valid && rsp_ready) begin
         n_rsp++;
         if (exp_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL rsp_unexpected: got tag %0d status %0d, expected no response",
                     rsp_tag, rsp_status);
         end else begin
            e = exp_q.pop_front();
            checkOutput("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            checkOutput("rsp_status", 32'(rsp_status), 32'(e.status));
            checkOutput("irq", 32'(irq), 32'd1);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (t_accel_start) begin t_n_start++; t_start_edge = edge_cnt; end
      if (t_accel_clr) begin t_n_clr++; t_clr_edge = edge_cnt; end
      if (t_rsp_valid && t_rsp_ready) begin
         t_n_rsp++;
         if (t_exp_q.size() == 0) begin
            tests_run++; tests_failed++;
            $display("[TB] FAIL t_rsp_unexpected: got tag %0d status %0d, expected no response",
                     t_rsp_tag, t_rsp_status);
         end else begin
            e = t_exp_q.pop_front();
            checkOutput("t_rsp_tag", 32'(t_rsp_tag), 32'(e.tag));
            checkOutput("t_rsp_status", 32'(t_rsp_status), 32'(e.status));
            checkOutput("t_irq", 32'(t_irq), 32'd1);
         end
      end
   end

   // Drives one command and returns #1 after the accepting edge.
   task automatic applyStimulus(input bit short_dut, input logic [LEN_W-1:0] len,
                                input logic [TAG_W-1:0] tag);
      int c = 0;
      if (short_dut) begin t_cmd_valid = 1'b1; t_cmd_len = len; t_cmd_tag = tag; end
      else begin cmd_valid = 1'b1; cmd_len = len; cmd_tag = tag; end
      while (!(short_dut ? t_cmd_ready : cmd_ready) && c < 500) begin
         @(posedge clk); #1; c++;
      end
      if (!(short_dut ? t_cmd_ready : cmd_ready)) begin
         tests_run++; tests_failed++;
         $display("[TB] FAIL cmd_accept_timeout: got cmd_ready 0, expected 1 for tag %0d", tag);
      end
      @(posedge clk); #1;
      accept_edge = edge_cnt;
      if (short_dut) t_cmd_valid = 1'b0; else cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input bit short_dut, input int target, input string name);
      int c = 0;
      while ((short_dut ? t_n_rsp : n_rsp) < target && c < 2000) begin
         @(posedge clk); c++;
      end
      #1;
      if ((short_dut ? t_n_rsp : n_rsp) < target) begin
         tests_run++; tests_failed++;
         $display("[TB] FAIL %s: got %0d responses, expected %0d", name,
                  short_dut ? t_n_rsp : n_rsp, target);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checkOutput({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
      checkOutput({name, "_accel_start"}, 32'(accel_start), 32'd0);
      checkOutput({name, "_accel_len"}, 32'(accel_len), 32'd0);
      checkOutput({name, "_accel_clr"}, 32'(accel_clr), 32'd0);
      checkOutput({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      checkOutput({name, "_rsp_tag"}, 32'(rsp_tag), 32'd0);
      checkOutput({name, "_rsp_status"}, 32'(rsp_status), 32'(STS_OK));
      checkOutput({name, "_irq"}, 32'(irq), 32'd0);
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      checkOutput({name, "_q_count"}, 32'(q_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int s0, c0, cnt, stable, spurious;
      cmd_valid = 1'b0; cmd_len = '0; cmd_tag = '0; rsp_ready = 1'b1;
      t_cmd_valid = 1'b0; t_cmd_len = '0; t_cmd_tag = '0; t_rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      checkOutput("reset_t_cmd_ready", 32'(t_cmd_ready), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic job: done 20 cycles after start, clear one cycle later.
      done_delay = 20;
      exp_q.push_back('{tag: 4'd3, status: STS_OK});
      s0 = n_start; c0 = n_clr;
      applyStimulus(1'b0, 6'd32, 4'd3);
      cnt = accept_edge;
      wait_rsp(1'b0, 1, "basic_rsp_wait");
      checkOutput("basic_starts", 32'(n_start - s0), 32'd1);
      checkOutput("basic_clears", 32'(n_clr - c0), 32'd1);
      checkOutput("basic_start_latency", 32'(start_edge - cnt), 32'd1);
      checkOutput("basic_done_to_clr", 32'(clr_edge - start_edge), 32'd21);
      checkOutput("basic_accel_len", 32'(start_len), 32'd32);

      // Zero length: reported as BADLEN without touching the accelerator.
      exp_q.push_back('{tag: 4'd5, status: STS_BADLEN});
      s0 = n_start; c0 = n_clr;
      applyStimulus(1'b0, 6'd0, 4'd5);
      wait_rsp(1'b0, 2, "badlen_rsp_wait");
      checkOutput("badlen_no_start", 32'(n_start - s0), 32'd0);
      checkOutput("badlen_no_clr", 32'(n_clr - c0), 32'd0);

      // Queue full: one job running plus four queued.
      done_delay = 30;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back('{tag: TAG_W'(i), status: STS_OK});
         applyStimulus(1'b0, 6'd8, TAG_W'(i));
      end
      checkOutput("full_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("full_q_count", 32'(q_count), 32'd4);
      checkOutput("full_busy", 32'(busy), 32'd1);
      wait_rsp(1'b0, 7, "full_rsp_wait");
      checkOutput("full_q_drained", 32'(q_count), 32'd0);

      // Response back-pressure: response held stable, next job not started.
      rsp_ready = 1'b0;
      done_delay = 5;
      exp_q.push_back('{tag: 4'd9, status: STS_OK});
      applyStimulus(1'b0, 6'd16, 4'd9);
      cnt = 0;
      while (!rsp_valid && cnt < 200) begin @(posedge clk); #1; cnt++; end
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      exp_q.push_back('{tag: 4'd10, status: STS_OK});
      applyStimulus(1'b0, 6'd16, 4'd10);
      s0 = n_start;
      stable = 1;
      repeat (10) @(negedge clk)
         if (!rsp_valid || rsp_tag != 4'd9 || rsp_status != STS_OK || !irq) stable = 0;
      checkOutput("bp_rsp_stable", 32'(stable), 32'd1);
      checkOutput("bp_no_start", 32'(n_start - s0), 32'd0);
      checkOutput("bp_q_count", 32'(q_count), 32'd1);
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_rsp(1'b0, 9, "bp_rsp_wait");

      // Reset mid-RUN with a job still queued.
      done_delay = 0;
      s0 = n_start;
      applyStimulus(1'b0, 6'd20, 4'd12);
      applyStimulus(1'b0, 6'd20, 4'd13);
      cnt = 0;
      while (n_start == s0 && cnt < 200) begin @(posedge clk); cnt++; end
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("post_reset_q_count", 32'(q_count), 32'd0);
      checkOutput("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
      spurious = 0;
      repeat (10) @(negedge clk) if (rsp_valid) spurious = 1;
      checkOutput("post_reset_no_rsp", 32'(spurious), 32'd0);

      // Timeout on the short instance: start cycle, 16 RUN cycles, then clear.
      @(posedge clk); #1;
      t_done_delay = 0;
      t_exp_q.push_back('{tag: 4'd7, status: STS_TIMEOUT});
      applyStimulus(1'b1, 6'd4, 4'd7);
      wait_rsp(1'b1, 1, "timeout_rsp_wait");
      checkOutput("timeout_start_to_clr", 32'(t_clr_edge - t_start_edge), 32'(TMO_SHORT + 1));
      checkOutput("timeout_starts", 32'(t_n_start), 32'd1);
      checkOutput("timeout_clears", 32'(t_n_clr), 32'd1);

      // Done on the same cycle the timer reaches zero: OK wins.
      t_done_delay = TMO_SHORT;
      t_exp_q.push_back('{tag: 4'd8, status: STS_OK});
      applyStimulus(1'b1, 6'd4, 4'd8);
      wait_rsp(1'b1, 2, "collide_rsp_wait");
      checkOutput("collide_start_to_clr", 32'(t_clr_edge - t_start_edge), 32'(TMO_SHORT + 1));

      repeat (3) @(posedge clk); #1;
      checkOutput("sb_main_empty", 32'(exp_q.size()), 32'd0);
      checkOutput("sb_short_empty", 32'(t_exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
